instruction_decode: RTL and testbench

//  RV32I decode stage: consumes the IF/ID pipeline register outputs, reads the register file,

---
 rtl/rv32i_pkg.sv | 53 +++++
 rtl/register_file.sv | 36 +++
 rtl/instruction_decode.sv | 171 +++++++++++++++++
 tb/tb_instruction_decode.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU operation and immediate-format enums,
// and helpers for immediate generation and ALU-op selection.
package rv32i_pkg;

  localparam int XLEN     = 32;
  localparam int NUM_REGS = 32;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
  } imm_fmt_e;

  function automatic logic [31:0] gen_imm(input imm_fmt_e fmt, input logic [31:0] instr);
    case (fmt)
      IMM_I:   gen_imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   gen_imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   gen_imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   gen_imm = {instr[31:12], 12'b0};
      IMM_J:   gen_imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: gen_imm = '0;
    endcase
  endfunction

  // sub_alt selects SUB for funct3 000 (OP only); sra_alt selects SRA for funct3 101.
  function automatic alu_op_e alu_op_of(input logic [2:0] funct3, input logic sub_alt,
                                        input logic sra_alt);
    case (funct3)
      3'b000:  alu_op_of = sub_alt ? ALU_SUB : ALU_ADD;
      3'b001:  alu_op_of = ALU_SLL;
      3'b010:  alu_op_of = ALU_SLT;
      3'b011:  alu_op_of = ALU_SLTU;
      3'b100:  alu_op_of = ALU_XOR;
      3'b101:  alu_op_of = sra_alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_op_of = ALU_OR;
      default: alu_op_of = ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/register_file.sv
// Architectural register file: two asynchronous read ports with same-cycle write-back
// bypass, one synchronous write port, x0 hardwired to zero.
module register_file #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   ra1,
  input  logic [AW-1:0]   ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  input  logic            we,
  input  logic [AW-1:0]   wa,
  input  logic [XLEN-1:0] wd
);

  logic [XLEN-1:0] regs [NUM_REGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (we && wa != '0) begin
      regs[wa] <= wd;
    end
  end

  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (ra1 != '0) rd1 = (we && wa == ra1) ? wd : regs[ra1];
    if (ra2 != '0) rd2 = (we && wa == ra2) ? wd : regs[ra2];
  end

endmodule

// File: rtl/instruction_decode.sv
// RV32I decode stage: decoder, load-use hazard detection and the ID/EX pipeline register.
// Priority each cycle is flush, then stall, then normal issue.
module instruction_decode
  import rv32i_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic [XLEN-1:0] i_if_id_pc,
  input  logic [31:0]     i_if_id_instruction,
  input  logic            i_if_id_valid,
  input  logic            i_flush,
  input  logic            i_wb_we,
  input  logic [4:0]      i_wb_rd,
  input  logic [XLEN-1:0] i_wb_data,
  output logic            o_stall,
  output logic            o_id_ex_valid,
  output logic [XLEN-1:0] o_id_ex_pc,
  output logic [XLEN-1:0] o_id_ex_rs1_data,
  output logic [XLEN-1:0] o_id_ex_rs2_data,
  output logic [XLEN-1:0] o_id_ex_imm,
  output logic [4:0]      o_id_ex_rs1,
  output logic [4:0]      o_id_ex_rs2,
  output logic [4:0]      o_id_ex_rd,
  output logic [2:0]      o_id_ex_funct3,
  output logic [3:0]      o_id_ex_alu_op,
  output logic            o_id_ex_alu_src,
  output logic            o_id_ex_mem_read,
  output logic            o_id_ex_mem_write,
  output logic            o_id_ex_mem_to_reg,
  output logic            o_id_ex_reg_write,
  output logic            o_id_ex_branch,
  output logic            o_id_ex_jump,
  output logic            o_id_ex_illegal
);

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    alu_op_e         alu_op;
    logic            alu_src;
    logic            mem_read;
    logic            mem_write;
    logic            mem_to_reg;
    logic            reg_write;
    logic            branch;
    logic            jump;
    logic            illegal;
  } id_ex_t;

  id_ex_t          id_ex_d, id_ex_q, ctrl;
  imm_fmt_e        imm_fmt;
  logic            rs1_used, rs2_used, load_use, issue;
  logic [XLEN-1:0] rs1_data, rs2_data;

  wire [31:0] instr  = i_if_id_instruction;
  wire [4:0]  rs1    = instr[19:15];
  wire [4:0]  rs2    = instr[24:20];
  wire [2:0]  funct3 = instr[14:12];

  register_file #(.XLEN(XLEN), .NUM_REGS(NUM_REGS)) u_register_file (
    .clk   (i_clk),
    .rst_n (i_reset_n),
    .ra1   (rs1),
    .ra2   (rs2),
    .rd1   (rs1_data),
    .rd2   (rs2_data),
    .we    (i_wb_we),
    .wa    (i_wb_rd),
    .wd    (i_wb_data)
  );

  always_comb begin
    ctrl     = '0;
    imm_fmt  = IMM_NONE;
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    case (instr[6:0])
      OPC_LUI: begin
        imm_fmt = IMM_U; ctrl.alu_op = ALU_PASS_B; ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1;
      end
      OPC_AUIPC: begin
        imm_fmt = IMM_U; ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1;
      end
      OPC_JAL: begin
        imm_fmt = IMM_J; ctrl.jump = 1'b1; ctrl.reg_write = 1'b1;
      end
      OPC_JALR: begin
        imm_fmt = IMM_I; rs1_used = 1'b1;
        ctrl.jump = 1'b1; ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1;
      end
      OPC_BRANCH: begin
        imm_fmt = IMM_B; rs1_used = 1'b1; rs2_used = 1'b1;
        ctrl.branch = 1'b1; ctrl.alu_op = ALU_SUB;
      end
      OPC_LOAD: begin
        imm_fmt = IMM_I; rs1_used = 1'b1; ctrl.alu_src = 1'b1;
        ctrl.mem_read = 1'b1; ctrl.mem_to_reg = 1'b1; ctrl.reg_write = 1'b1;
      end
      OPC_STORE: begin
        imm_fmt = IMM_S; rs1_used = 1'b1; rs2_used = 1'b1;
        ctrl.alu_src = 1'b1; ctrl.mem_write = 1'b1;
      end
      OPC_OP_IMM: begin
        imm_fmt = IMM_I; rs1_used = 1'b1; ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1;
        ctrl.alu_op = alu_op_of(funct3, 1'b0, instr[30]);
      end
      OPC_OP: begin
        rs1_used = 1'b1; rs2_used = 1'b1; ctrl.reg_write = 1'b1;
        ctrl.alu_op = alu_op_of(funct3, instr[30], instr[30]);
      end
      default: ctrl.illegal = 1'b1;
    endcase
  end

  // Only a load still sitting in ID/EX can create a hazard forwarding cannot cover.
  assign load_use = o_id_ex_valid && o_id_ex_mem_read && o_id_ex_rd != '0 &&
                    ((rs1_used && o_id_ex_rd == rs1) || (rs2_used && o_id_ex_rd == rs2));
  assign o_stall  = i_if_id_valid && load_use && !i_flush;
  assign issue    = i_if_id_valid && !i_flush && !load_use;

  always_comb begin
    id_ex_d = '0;
    if (issue) begin
      id_ex_d          = ctrl;
      id_ex_d.valid    = 1'b1;
      id_ex_d.pc       = i_if_id_pc;
      id_ex_d.rs1_data = rs1_data;
      id_ex_d.rs2_data = rs2_data;
      id_ex_d.imm      = gen_imm(imm_fmt, instr);
      id_ex_d.rs1      = rs1_used ? rs1 : 5'd0;
      id_ex_d.rs2      = rs2_used ? rs2 : 5'd0;
      id_ex_d.rd       = instr[11:7];
      id_ex_d.funct3   = funct3;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) id_ex_q <= '0;
    else            id_ex_q <= id_ex_d;
  end

  assign o_id_ex_valid      = id_ex_q.valid;
  assign o_id_ex_pc         = id_ex_q.pc;
  assign o_id_ex_rs1_data   = id_ex_q.rs1_data;
  assign o_id_ex_rs2_data   = id_ex_q.rs2_data;
  assign o_id_ex_imm        = id_ex_q.imm;
  assign o_id_ex_rs1        = id_ex_q.rs1;
  assign o_id_ex_rs2        = id_ex_q.rs2;
  assign o_id_ex_rd         = id_ex_q.rd;
  assign o_id_ex_funct3     = id_ex_q.funct3;
  assign o_id_ex_alu_op     = id_ex_q.alu_op;
  assign o_id_ex_alu_src    = id_ex_q.alu_src;
  assign o_id_ex_mem_read   = id_ex_q.mem_read;
  assign o_id_ex_mem_write  = id_ex_q.mem_write;
  assign o_id_ex_mem_to_reg = id_ex_q.mem_to_reg;
  assign o_id_ex_reg_write  = id_ex_q.reg_write;
  assign o_id_ex_branch     = id_ex_q.branch;
  assign o_id_ex_jump       = id_ex_q.jump;
  assign o_id_ex_illegal    = id_ex_q.illegal;

endmodule

// File: tb/tb_instruction_decode.sv
// Directed bench for instruction_decode: hand-encoded RV32I instructions with
// hand-computed decode, bypass, hazard, flush and reset expectations.
module tb_instruction_decode;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc, instr, wb_data;
  logic        valid, flush, wb_we;
  logic [4:0]  wb_rd;
  logic        stall, ex_valid, ex_alu_src, ex_mem_read, ex_mem_write, ex_mem_to_reg;
  logic        ex_reg_write, ex_branch, ex_jump, ex_illegal;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [2:0]  ex_funct3;
  logic [3:0]  ex_alu_op;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  instruction_decode dut (
    .i_clk               (clk),
    .i_reset_n           (rst_n),
    .i_if_id_pc          (pc),
    .i_if_id_instruction (instr),
    .i_if_id_valid       (valid),
    .i_flush             (flush),
    .i_wb_we             (wb_we),
    .i_wb_rd             (wb_rd),
    .i_wb_data           (wb_data),
    .o_stall             (stall),
    .o_id_ex_valid       (ex_valid),
    .o_id_ex_pc          (ex_pc),
    .o_id_ex_rs1_data    (ex_rs1_data),
    .o_id_ex_rs2_data    (ex_rs2_data),
    .o_id_ex_imm         (ex_imm),
    .o_id_ex_rs1         (ex_rs1),
    .o_id_ex_rs2         (ex_rs2),
    .o_id_ex_rd          (ex_rd),
    .o_id_ex_funct3      (ex_funct3),
    .o_id_ex_alu_op      (ex_alu_op),
    .o_id_ex_alu_src     (ex_alu_src),
    .o_id_ex_mem_read    (ex_mem_read),
    .o_id_ex_mem_write   (ex_mem_write),
    .o_id_ex_mem_to_reg  (ex_mem_to_reg),
    .o_id_ex_reg_write   (ex_reg_write),
    .o_id_ex_branch      (ex_branch),
    .o_id_ex_jump        (ex_jump),
    .o_id_ex_illegal     (ex_illegal)
  );

  task automatic apply_stimulus(input logic v, input logic [31:0] p, input logic [31:0] i,
                                input logic f, input logic we, input logic [4:0] rd,
                                input logic [31:0] d);
    valid = v; pc = p; instr = i; flush = f; wb_we = we; wb_rd = rd; wb_data = d;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Outputs are sampled 1 ns after the rising edge, well clear of it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    apply_stimulus(1'b1, 32'h0, 32'h00128333, 1'b0, 1'b0, 5'd0, 32'h0);
    step();
    check_output("reset_valid", ex_valid, 0);
    check_output("reset_reg_write", ex_reg_write, 0);
    check_output("reset_stall", stall, 0);
    rst_n = 1'b1;

    // ADDI x1,x0,5 while WB writes x2
    apply_stimulus(1'b1, 32'h100, 32'h00500093, 1'b0, 1'b1, 5'd2, 32'h0000_1000);
    step();
    check_output("addi_valid", ex_valid, 1);
    check_output("addi_rd", ex_rd, 1);
    check_output("addi_imm", ex_imm, 5);
    check_output("addi_alu_src", ex_alu_src, 1);
    check_output("addi_reg_write", ex_reg_write, 1);
    check_output("addi_pc", ex_pc, 32'h100);

    // ADD x4,x3,x3 with same-cycle WB of x3
    apply_stimulus(1'b1, 32'h104, 32'h00318233, 1'b0, 1'b1, 5'd3, 32'hDEAD_BEEF);
    step();
    check_output("bypass_rs1", ex_rs1_data, 32'hDEAD_BEEF);
    check_output("bypass_rs2", ex_rs2_data, 32'hDEAD_BEEF);
    check_output("add_alu_src", ex_alu_src, 0);

    // ADDI x7,x1,-1 with WB x1=0x55
    apply_stimulus(1'b1, 32'h108, 32'hFFF08393, 1'b0, 1'b1, 5'd1, 32'h55);
    step();
    check_output("addi_neg_imm", ex_imm, 32'hFFFF_FFFF);
    check_output("addi_rs1_data", ex_rs1_data, 32'h55);

    // LW x5,0(x2) then dependent ADD x6,x5,x1
    apply_stimulus(1'b1, 32'h10C, 32'h00012283, 1'b0, 1'b0, 5'd0, 32'h0);
    step();
    check_output("lw_mem_read", ex_mem_read, 1);
    check_output("lw_mem_to_reg", ex_mem_to_reg, 1);
    check_output("lw_rs1_data", ex_rs1_data, 32'h1000);
    apply_stimulus(1'b1, 32'h110, 32'h00128333, 1'b0, 1'b0, 5'd0, 32'h0);
    #1;
    check_output("load_use_stall", stall, 1);
    step();
    check_output("stall_bubble_valid", ex_valid, 0);
    check_output("stall_bubble_reg_write", ex_reg_write, 0);
    check_output("stall_released", stall, 0);
    step();
    check_output("add_after_stall_valid", ex_valid, 1);
    check_output("add_after_stall_rd", ex_rd, 6);
    check_output("add_after_stall_rs1", ex_rs1, 5);
    check_output("add_after_stall_rs2_data", ex_rs2_data, 32'h55);

    // Load again; invalid slot must not stall, flush must override stall
    apply_stimulus(1'b1, 32'h114, 32'h00012283, 1'b0, 1'b0, 5'd0, 32'h0);
    step();
    apply_stimulus(1'b0, 32'h118, 32'h00128333, 1'b0, 1'b0, 5'd0, 32'h0);
    #1;
    check_output("invalid_no_stall", stall, 0);
    apply_stimulus(1'b1, 32'h118, 32'h00128333, 1'b1, 1'b0, 5'd0, 32'h0);
    #1;
    check_output("flush_no_stall", stall, 0);
    step();
    check_output("flush_bubble", ex_valid, 0);

    // WB to x0 must be ignored, including the bypass path
    apply_stimulus(1'b1, 32'h11C, 32'h00000033, 1'b0, 1'b1, 5'd0, 32'h1234);
    step();
    check_output("x0_bypass", ex_rs1_data, 0);
    apply_stimulus(1'b1, 32'h120, 32'h00000033, 1'b0, 1'b0, 5'd0, 32'h0);
    step();
    check_output("x0_read", ex_rs2_data, 0);

    // Illegal opcode 0x7F
    apply_stimulus(1'b1, 32'h124, 32'h0000007F, 1'b0, 1'b0, 5'd0, 32'h0);
    step();
    check_output("illegal_valid", ex_valid, 1);
    check_output("illegal_flag", ex_illegal, 1);
    check_output("illegal_reg_write", ex_reg_write, 0);

    // SW x3,-4(x2)
    apply_stimulus(1'b1, 32'h128, 32'hFE312E23, 1'b0, 1'b0, 5'd0, 32'h0);
    step();
    check_output("sw_imm", ex_imm, 32'hFFFF_FFFC);
    check_output("sw_mem_write", ex_mem_write, 1);
    check_output("sw_rs2_data", ex_rs2_data, 32'hDEAD_BEEF);
    check_output("sw_reg_write", ex_reg_write, 0);

    // BEQ x1,x2,+8
    apply_stimulus(1'b1, 32'h12C, 32'h00208463, 1'b0, 1'b0, 5'd0, 32'h0);
    step();
    check_output("beq_imm", ex_imm, 8);
    check_output("beq_branch", ex_branch, 1);
    check_output("beq_alu_op", ex_alu_op, 4'd1);

    // LUI x8,0x12345: rs1 field is non-zero but unused
    apply_stimulus(1'b1, 32'h130, 32'h12345437, 1'b0, 1'b0, 5'd0, 32'h0);
    step();
    check_output("lui_imm", ex_imm, 32'h1234_5000);
    check_output("lui_alu_op", ex_alu_op, 4'd10);
    check_output("lui_rs1_unused", ex_rs1, 0);

    // JAL x1,-4
    apply_stimulus(1'b1, 32'h134, 32'hFFDFF0EF, 1'b0, 1'b0, 5'd0, 32'h0);
    step();
    check_output("jal_imm", ex_imm, 32'hFFFF_FFFC);
    check_output("jal_jump", ex_jump, 1);
    check_output("jal_reg_write", ex_reg_write, 1);

    apply_stimulus(1'b0, 32'h138, 32'h00500093, 1'b0, 1'b0, 5'd0, 32'h0);
    step();
    check_output("invalid_bubble", ex_valid, 0);

    // Reset in the middle of the stream
    apply_stimulus(1'b1, 32'h13C, 32'h00500093, 1'b0, 1'b0, 5'd0, 32'h0);
    step();
    check_output("pre_reset_valid", ex_valid, 1);
    rst_n = 1'b0;
    #1;
    check_output("async_reset_valid", ex_valid, 0);
    check_output("async_reset_imm", ex_imm, 0);
    check_output("async_reset_reg_write", ex_reg_write, 0);
    step();
    rst_n = 1'b1;
    apply_stimulus(1'b1, 32'h140, 32'h00318233, 1'b0, 1'b0, 5'd0, 32'h0);
    step();
    check_output("post_reset_valid", ex_valid, 1);
    check_output("post_reset_x3", ex_rs1_data, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
